io_regs: RTL and testbench

Memory-mapped control/status register block on the CPU data bus, the second bus slave in the 0x0100_0000–0x0100_0FFF window. It provides a simulation stop flag (CTRL) and a byte-wide console channel (CONSOLE). Console output uses a req/ack handshake, and console input is captured from hardware. Register reads are combinational and complete in the same cycle as the access, so the bus ready signal is tied high.

---
 rtl/io_regs_pkg.sv | 24 ++
 rtl/io_regs_hs_req.sv | 31 +++
 rtl/io_regs.sv | 100 ++++++++++
 tb/tb_io_regs.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_regs_pkg.sv
//------------------------------------------------------------------------------
// io_regs_pkg : address map and field positions for the io_regs block
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package io_regs_pkg;

  localparam logic [31:0] ADDR_CTRL    = 32'h0000_0000;
  localparam logic [31:0] ADDR_CONSOLE = 32'h0000_0004;

  localparam int CTRL_STOP_BIT    = 0;
  localparam int CONSOLE_DATA_LSB = 0;
  localparam int CONSOLE_DATA_W   = 8;
  localparam int CONSOLE_SEND_BIT = 8;

  // Word-address match; the byte offset bits never take part in decode.
  function automatic logic addr_hit(input logic [31:0] addr, input logic [31:0] base);
    return addr[31:2] == base[31:2];
  endfunction

endpackage

`default_nettype wire

// File: rtl/io_regs_hs_req.sv
//------------------------------------------------------------------------------
// hs_req   : set/ack request flop, set has priority over the acknowledge clear
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hs_req (
  input  logic clock,
  input  logic resetn,
  input  logic i_set,
  input  logic i_ack,
  output logic o_req
);

  logic r_req;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_req <= 1'b0;
    end else if (i_set) begin
      r_req <= 1'b1;
    end else if (r_req && i_ack) begin
      r_req <= 1'b0;
    end
  end

  assign o_req = r_req;

endmodule

`default_nettype wire

// File: rtl/io_regs.sv
//------------------------------------------------------------------------------
// io_regs  : CTRL/CONSOLE memory-mapped register block, zero-wait-state reads
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module io_regs
  import io_regs_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_data,
  input  logic [3:0]  i_ben,
  input  logic        i_write,
  input  logic        i_read,
  output logic        o_ctrl_stop,
  input  logic [7:0]  i_console_data,
  input  logic        i_console_valid,
  output logic [7:0]  o_console_data,
  output logic        o_console_send_hsreq,
  input  logic        i_console_send_hsack,
  input  logic        i_console_send,
  output logic        o_console__rnotify
);

  localparam int c_STOP_BYTE = CTRL_STOP_BIT / 8;
  localparam int c_DATA_BYTE = CONSOLE_DATA_LSB / 8;
  localparam int c_SEND_BYTE = CONSOLE_SEND_BIT / 8;

  logic                      w_sel_ctrl;
  logic                      w_sel_console;
  logic                      w_wr_ctrl;
  logic                      w_wr_console;
  logic                      w_send_set;
  logic                      w_send_pending;
  logic                      r_stop;
  logic [CONSOLE_DATA_W-1:0] r_tx;
  logic [CONSOLE_DATA_W-1:0] r_rx;
  logic                      r_rnotify;
  logic                      w_unused;

  assign w_sel_ctrl    = addr_hit(i_addr, ADDR_CTRL);
  assign w_sel_console = addr_hit(i_addr, ADDR_CONSOLE);
  assign w_wr_ctrl     = i_write && w_sel_ctrl;
  assign w_wr_console  = i_write && w_sel_console;

  // Writing 0 to SEND is a no-op, so only a set is derived from the bus.
  assign w_send_set = (w_wr_console && i_ben[c_SEND_BYTE] && i_data[CONSOLE_SEND_BIT])
                      || i_console_send;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_stop    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rnotify <= 1'b0;
    end else begin
      if (w_wr_ctrl && i_ben[c_STOP_BYTE]) begin
        r_stop <= i_data[CTRL_STOP_BIT];
      end
      if (w_wr_console && i_ben[c_DATA_BYTE]) begin
        r_tx <= i_data[CONSOLE_DATA_LSB +: CONSOLE_DATA_W];
      end
      if (i_console_valid) begin
        r_rx <= i_console_data;
      end
      r_rnotify <= i_read && !i_write && w_sel_console;
    end
  end

  hs_req u_send_req (
    .clock  (clock),
    .resetn (resetn),
    .i_set  (w_send_set),
    .i_ack  (i_console_send_hsack),
    .o_req  (w_send_pending)
  );

  always_comb begin
    o_data = '0;
    if (w_sel_ctrl) begin
      o_data[CTRL_STOP_BIT] = r_stop;
    end else if (w_sel_console) begin
      o_data[CONSOLE_DATA_LSB +: CONSOLE_DATA_W] = r_rx;
      o_data[CONSOLE_SEND_BIT]                   = w_send_pending;
    end
  end

  assign o_ctrl_stop          = r_stop;
  assign o_console_data       = r_tx;
  assign o_console_send_hsreq = w_send_pending;
  assign o_console__rnotify   = r_rnotify;

  assign w_unused = ^{i_addr[1:0], i_data[31:9]};

endmodule

`default_nettype wire

// File: tb/tb_io_regs.sv
//------------------------------------------------------------------------------
// tb_io_regs : directed vector table, hand sequences and randomized model check
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_io_regs;

  logic        clock;
  logic        resetn;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic [3:0]  i_ben;
  logic        i_write;
  logic        i_read;
  logic        o_ctrl_stop;
  logic [7:0]  i_console_data;
  logic        i_console_valid;
  logic [7:0]  o_console_data;
  logic        o_console_send_hsreq;
  logic        i_console_send_hsack;
  logic        i_console_send;
  logic        o_console__rnotify;

  io_regs dut (
    .clock                (clock),
    .resetn               (resetn),
    .i_addr               (i_addr),
    .i_data               (i_data),
    .o_data               (o_data),
    .i_ben                (i_ben),
    .i_write              (i_write),
    .i_read               (i_read),
    .o_ctrl_stop          (o_ctrl_stop),
    .i_console_data       (i_console_data),
    .i_console_valid      (i_console_valid),
    .o_console_data       (o_console_data),
    .o_console_send_hsreq (o_console_send_hsreq),
    .i_console_send_hsack (i_console_send_hsack),
    .i_console_send       (i_console_send),
    .o_console__rnotify   (o_console__rnotify)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rn;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  ben;
    logic        wr;
    logic        rd;
    logic [7:0]  cd;
    logic        cv;
    logic        snd;
    logic        ack;
    logic [31:0] e_data;
    logic        e_stop;
    logic [7:0]  e_tx;
    logic        e_req;
    logic        e_ntf;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: what software would see of each register.
  logic       m_stop, m_pend, m_ntf;
  logic [7:0] m_tx, m_rx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < 32'h4)      return {31'd0, m_stop};
    else if (a < 32'h8) return {23'd0, m_pend, m_rx};
    else                return 32'd0;
  endfunction

  task automatic model_step(input vec_t v);
    logic on_ctrl, on_con, set;
    on_ctrl = (v.addr < 32'h4);
    on_con  = (v.addr >= 32'h4) && (v.addr < 32'h8);
    if (!v.rn) begin
      m_stop = 0; m_tx = 0; m_rx = 0; m_pend = 0; m_ntf = 0;
    end else begin
      if (v.wr && on_ctrl && v.ben[0]) m_stop = v.data[0];
      if (v.wr && on_con && v.ben[0])  m_tx = v.data[7:0];
      if (v.cv) m_rx = v.cd;
      set = (v.wr && on_con && v.ben[1] && v.data[8]) || v.snd;
      if (set)                 m_pend = 1;
      else if (m_pend && v.ack) m_pend = 0;
      m_ntf = v.rd && !v.wr && on_con;
    end
  endtask

  task automatic do_cycle(input vec_t v, input bit chk_en);
    @(negedge clock);
    resetn = v.rn; i_addr = v.addr; i_data = v.data; i_ben = v.ben;
    i_write = v.wr; i_read = v.rd; i_console_data = v.cd; i_console_valid = v.cv;
    i_console_send = v.snd; i_console_send_hsack = v.ack;
    #1;
    if (chk_en) begin
      chk("model_o_data", o_data, model_read(v.addr));
      chk("model_stop", {31'd0, o_ctrl_stop}, {31'd0, m_stop});
      chk("model_tx", {24'd0, o_console_data}, {24'd0, m_tx});
      chk("model_hsreq", {31'd0, o_console_send_hsreq}, {31'd0, m_pend});
      chk("model_rnotify", {31'd0, o_console__rnotify}, {31'd0, m_ntf});
    end
    model_step(v);
  endtask

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] ben, input logic wr, input logic rd,
                              input logic [7:0] cd, input logic cv, input logic snd,
                              input logic ack, input logic [31:0] e_data, input logic e_stop,
                              input logic [7:0] e_tx, input logic e_req, input logic e_ntf);
    vec_t v;
    v.rn = 1; v.addr = addr; v.data = data; v.ben = ben; v.wr = wr; v.rd = rd;
    v.cd = cd; v.cv = cv; v.snd = snd; v.ack = ack;
    v.e_data = e_data; v.e_stop = e_stop; v.e_tx = e_tx; v.e_req = e_req; v.e_ntf = e_ntf;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] addr, input logic ack);
    return mk(addr, 0, 0, 0, 0, 0, 0, 0, ack, 0, 0, 0, 0, 0);
  endfunction

  vec_t tbl[31];
  vec_t v;

  initial begin
    // Expected fields are the outputs seen during the vector's own cycle.
    tbl[0]  = mk(32'h0, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(32'h4, 0, 0, 0, 1, 0, 0, 0, 1, 32'h0, 0, 8'h00, 0, 0);
    tbl[2]  = mk(32'h4, 32'h148, 4'h3, 1, 0, 0, 0, 0, 1, 32'h0, 0, 8'h00, 0, 1);
    tbl[3]  = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 8'h48, 1, 0);
    tbl[4]  = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 8'h48, 0, 0);
    tbl[5]  = mk(32'h4, 32'h169, 4'h3, 1, 0, 0, 0, 0, 1, 32'h0, 0, 8'h48, 0, 0);
    tbl[6]  = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 8'h69, 1, 0);
    tbl[7]  = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 8'h69, 0, 0);
    tbl[8]  = mk(32'h4, 32'h1AA, 4'h2, 1, 0, 0, 0, 0, 1, 32'h0, 0, 8'h69, 0, 0);
    tbl[9]  = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 0, 8'h69, 1, 0);
    tbl[10] = mk(32'h4, 32'h1AA, 4'h1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 8'h69, 0, 0);
    tbl[11] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 8'hAA, 0, 0);
    tbl[12] = mk(32'h4, 0, 0, 0, 0, 8'hA5, 1, 0, 1, 32'h0, 0, 8'hAA, 0, 0);
    tbl[13] = mk(32'h4, 0, 0, 0, 1, 0, 0, 0, 1, 32'hA5, 0, 8'hAA, 0, 0);
    tbl[14] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 0, 8'hAA, 0, 1);
    tbl[15] = mk(32'h4, 0, 4'h0, 1, 1, 0, 0, 0, 1, 32'hA5, 0, 8'hAA, 0, 0);
    tbl[16] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 0, 8'hAA, 0, 0);
    tbl[17] = mk(32'h0, 32'h1, 4'h1, 1, 0, 0, 0, 0, 1, 32'h0, 0, 8'hAA, 0, 0);
    tbl[18] = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 1, 8'hAA, 0, 0);
    tbl[19] = mk(32'h8, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 0, 1, 32'h0, 1, 8'hAA, 0, 0);
    tbl[20] = mk(32'h0100_0000, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 0, 1, 32'h0, 1, 8'hAA, 0, 0);
    tbl[21] = mk(32'h0100_0004, 32'hFFFF_FFFF, 4'hF, 1, 0, 0, 0, 0, 1, 32'h0, 1, 8'hAA, 0, 0);
    tbl[22] = mk(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1, 1, 8'hAA, 0, 0);
    tbl[23] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 1, 8'hAA, 0, 0);
    tbl[24] = mk(32'h4, 32'h100, 4'h2, 1, 0, 0, 0, 0, 1, 32'hA5, 1, 8'hAA, 0, 0);
    tbl[25] = mk(32'h4, 32'h100, 4'h2, 1, 0, 0, 0, 0, 1, 32'h1A5, 1, 8'hAA, 1, 0);
    tbl[26] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1A5, 1, 8'hAA, 1, 0);
    tbl[27] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 1, 8'hAA, 0, 0);
    tbl[28] = mk(32'h4, 0, 0, 0, 0, 0, 0, 1, 1, 32'hA5, 1, 8'hAA, 0, 0);
    tbl[29] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1A5, 1, 8'hAA, 1, 0);
    tbl[30] = mk(32'h4, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA5, 1, 8'hAA, 0, 0);

    resetn = 0; i_addr = 0; i_data = 0; i_ben = 0; i_write = 0; i_read = 0;
    i_console_data = 0; i_console_valid = 0; i_console_send = 0; i_console_send_hsack = 1;
    m_stop = 0; m_tx = 0; m_rx = 0; m_pend = 0; m_ntf = 0;

    v = idle(32'h0, 1);
    v.rn = 0;
    for (int i = 0; i < 5; i++) do_cycle(v, 0);

    for (int i = 0; i < 31; i++) begin
      do_cycle(tbl[i], 1);
      chk($sformatf("tbl%0d_o_data", i), o_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_stop", i), {31'd0, o_ctrl_stop}, {31'd0, tbl[i].e_stop});
      chk($sformatf("tbl%0d_tx", i), {24'd0, o_console_data}, {24'd0, tbl[i].e_tx});
      chk($sformatf("tbl%0d_hsreq", i), {31'd0, o_console_send_hsreq}, {31'd0, tbl[i].e_req});
      chk($sformatf("tbl%0d_rnotify", i), {31'd0, o_console__rnotify}, {31'd0, tbl[i].e_ntf});
    end

    // Reset wins over a simultaneous write and pending request.
    do_cycle(mk(32'h4, 32'h155, 4'h3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    v = mk(32'h0, 32'h1, 4'h1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.rn = 0;
    do_cycle(v, 1);
    do_cycle(idle(32'h4, 0), 1);
    chk("rst_override_stop", {31'd0, o_ctrl_stop}, 32'd0);
    chk("rst_override_tx", {24'd0, o_console_data}, 32'd0);
    chk("rst_override_data", o_data, 32'd0);
    chk("rst_override_req", {31'd0, o_console_send_hsreq}, 32'd0);

    // Held acknowledge keeps the request up until ack rises.
    do_cycle(mk(32'h4, 32'h100, 4'h2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1);
    for (int i = 0; i < 10; i++) begin
      do_cycle(idle(32'h4, 0), 1);
      chk("held_hsreq", {31'd0, o_console_send_hsreq}, 32'd1);
      chk("held_send_bit", {31'd0, o_data[8]}, 32'd1);
    end
    do_cycle(idle(32'h4, 1), 1);
    chk("ack_cycle_hsreq", {31'd0, o_console_send_hsreq}, 32'd1);
    do_cycle(idle(32'h4, 1), 1);
    chk("after_ack_hsreq", {31'd0, o_console_send_hsreq}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] addrs[4];
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8; addrs[3] = $urandom;
      v.rn   = ($urandom_range(0, 63) != 0);
      v.addr = addrs[$urandom_range(0, 3)] | {30'd0, 2'($urandom_range(0, 3))};
      v.data = $urandom;
      v.ben  = 4'($urandom);
      v.wr   = 1'($urandom);
      v.rd   = 1'($urandom);
      v.cd   = 8'($urandom);
      v.cv   = 1'($urandom);
      v.snd  = ($urandom_range(0, 7) == 0);
      v.ack  = 1'($urandom);
      do_cycle(v, 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
